axis_i2s_tx: RTL and testbench

- Sink end of the stereo AXIS sample stream produced by the FIR filter blocks.
- Accepts packets of two words: left first, then right with last=1.
- Double-buffers one stereo pair and serialises it onto a Philips-format I2S transmitter interface (SCLK, LRCK, SDATA) for the Pmod DAC.
- The clk input is the audio master clock (MCLK); MCLK forwarding to the pin is done outside this block.

---
 rtl/axis_i2s_tx.sv | 122 ++++++++++++
 tb/tb_axis_i2s_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_i2s_tx.sv
// rtl/axis_i2s_tx.sv - AXIS stereo-pair sink serialised onto a Philips I2S transmitter
// Runs on MCLK; one stereo pair per 2^FRAME_BITS clk frame, with double buffering.
module axis_i2s_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int FRAME_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic                  i2s_sclk,
    output logic                  i2s_lrck,
    output logic                  i2s_sdata,
    output logic                  underrun
);

    localparam int SLOT_W = FRAME_BITS - 3;
    localparam int SLOTS  = 1 << SLOT_W;
    localparam int PAD    = SLOTS - 1 - DATA_WIDTH;

    logic [FRAME_BITS-1:0] cnt_q, cnt_d;
    logic                  sclk_q, sclk_d;
    logic                  lrck_q, lrck_d;
    logic                  sdata_q, sdata_d;
    logic                  ready_q, ready_d;
    logic                  underrun_q, underrun_d;
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] stage_l_q, stage_l_d;
    logic [DATA_WIDTH-1:0] stage_r_q, stage_r_d;
    logic [DATA_WIDTH-1:0] active_l_q, active_l_d;
    logic [DATA_WIDTH-1:0] active_r_q, active_r_d;

    logic                  load;
    logic                  beat;
    logic [SLOT_W-1:0]     slot;
    logic [DATA_WIDTH-1:0] sample;
    logic [SLOTS-1:0]      word;

    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        load       = &cnt_q;
        beat       = s_axis_valid && ready_q;

        stage_l_d  = stage_l_q;
        stage_r_d  = stage_r_q;
        active_l_d = active_l_q;
        active_r_d = active_r_q;
        full_d     = full_q;

        // Load and an accepted right beat never collide while full, since ready is low then.
        if (load) begin
            if (full_q) begin
                active_l_d = stage_l_q;
                active_r_d = stage_r_q;
                full_d     = 1'b0;
            end else begin
                active_l_d = '0;
                active_r_d = '0;
            end
        end

        if (beat) begin
            if (s_axis_last) begin
                stage_r_d = s_axis_data;
                full_d    = 1'b1;
            end else begin
                stage_l_d = s_axis_data;
            end
        end

        ready_d    = ~full_d;
        underrun_d = load && !full_q;
        sclk_d     = cnt_d[1];
        lrck_d     = cnt_d[FRAME_BITS-1];

        // Slot word is MSB-first with a leading zero for the one-bit I2S delay.
        slot    = cnt_d[FRAME_BITS-2:2];
        sample  = cnt_d[FRAME_BITS-1] ? active_r_q : active_l_q;
        word    = SLOTS'(sample) << PAD;
        sdata_d = sdata_q;
        if (cnt_q[1:0] == 2'b11) begin
            sdata_d = word[~slot];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            sclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            sdata_q    <= 1'b0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            full_q     <= 1'b0;
            stage_l_q  <= '0;
            stage_r_q  <= '0;
            active_l_q <= '0;
            active_r_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            sclk_q     <= sclk_d;
            lrck_q     <= lrck_d;
            sdata_q    <= sdata_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
            full_q     <= full_d;
            stage_l_q  <= stage_l_d;
            stage_r_q  <= stage_r_d;
            active_l_q <= active_l_d;
            active_r_q <= active_r_d;
        end
    end

    assign s_axis_ready = ready_q;
    assign i2s_sclk     = sclk_q;
    assign i2s_lrck     = lrck_q;
    assign i2s_sdata    = sdata_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_axis_i2s_tx.sv
// tb/tb_axis_i2s_tx.sv - directed self-checking bench for axis_i2s_tx
// Captures whole frames slot by slot and compares against hand-built slot words.
module tb_axis_i2s_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        sclk, lrck, sdata, urun;
    logic [7:0]  m_cnt;
    int          n_cmp = 0;
    int          n_fail = 0;

    axis_i2s_tx #(.DATA_WIDTH(24), .FRAME_BITS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_data  (s_data),
        .s_axis_valid (s_valid),
        .s_axis_ready (s_ready),
        .s_axis_last  (s_last),
        .i2s_sclk     (sclk),
        .i2s_lrck     (lrck),
        .i2s_sdata    (sdata),
        .underrun     (urun)
    );

    always #5 clk = ~clk;

    // Reference frame counter, used only to know where in the frame the bench is.
    always @(posedge clk or posedge reset) begin
        if (reset) m_cnt <= 8'd0;
        else       m_cnt <= m_cnt + 8'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cnt(input logic [7:0] tgt);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_cnt !== tgt && n < 600);
        if (m_cnt !== tgt) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_cnt: cnt=%0d required %0d", m_cnt, tgt);
        end
    endtask

    task automatic send_beat(input logic [23:0] d, input logic l,
                             output logic [7:0] acc_cnt, output int stalls);
        bit acc = 1'b0;
        int n = 0;
        stalls  = 0;
        acc_cnt = 8'd0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (!acc && n < 600) begin
            if (s_ready === 1'b1) begin
                acc     = 1'b1;
                acc_cnt = m_cnt;
            end else begin
                stalls++;
            end
            @(negedge clk);
            n++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!acc) begin
            n_cmp++; n_fail++;
            $display("FAIL send_beat: data %h never accepted", d);
        end
    endtask

    // Call at the negedge where cnt==0; returns at the negedge where cnt==255.
    task automatic capture_frame(output logic [31:0] lw, output logic [31:0] rw,
                                 output logic ur, output int align_err, output int ur_err);
        lw = '0; rw = '0; align_err = 0; ur_err = 0;
        ur = urun;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            if (sclk !== m_cnt[1] || lrck !== m_cnt[7]) align_err++;
            if (i > 0 && urun !== 1'b0) ur_err++;
            if (i < 128 && i % 4 == 2)  lw[5'(31 - i / 4)] = sdata;
            if (i >= 128 && i % 4 == 2) rw[5'(31 - (i - 128) / 4)] = sdata;
        end
    endtask

    logic [31:0] lw, rw, lw2, rw2;
    logic        ur, ur2;
    int          ae, ue, ae2, ue2, stalls, dummy_st;
    logic [7:0]  acc_cnt, dummy_ac;

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({s_ready, sclk, lrck, sdata, urun} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 00000", {s_ready, sclk, lrck, sdata, urun});
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b required 1", s_ready);
        end
        wait_cnt(8'd0);
        capture_frame(lw, rw, ur, ae, ue);
        n_cmp++;
        if ({lw, rw} !== 64'h0) begin
            n_fail++; $display("FAIL idle_sdata: got %h %h required 0", lw, rw);
        end
        n_cmp++;
        if (ur !== 1'b1) begin
            n_fail++; $display("FAIL idle_underrun: got %b required 1", ur);
        end
        n_cmp++;
        if (ae !== 0 || ue !== 0) begin
            n_fail++; $display("FAIL idle_clocks: align_err %0d ur_err %0d required 0 0", ae, ue);
        end
    endtask

    task automatic test_basic_pair;
        send_beat(24'h800001, 1'b0, dummy_ac, dummy_st);
        send_beat(24'h7FFFFE, 1'b1, dummy_ac, dummy_st);
        wait_cnt(8'd0);
        capture_frame(lw, rw, ur, ae, ue);
        n_cmp++;
        if (lw !== {1'b0, 24'h800001, 7'h0}) begin
            n_fail++; $display("FAIL basic_left: got %h required %h", lw, {1'b0, 24'h800001, 7'h0});
        end
        n_cmp++;
        if (rw !== {1'b0, 24'h7FFFFE, 7'h0}) begin
            n_fail++; $display("FAIL basic_right: got %h required %h", rw, {1'b0, 24'h7FFFFE, 7'h0});
        end
        n_cmp++;
        if (ur !== 1'b0 || ae !== 0 || ue !== 0) begin
            n_fail++; $display("FAIL basic_frame: ur %b align_err %0d ur_err %0d required 0 0 0", ur, ae, ue);
        end
    endtask

    task automatic test_back_to_back;
        send_beat(24'h0ABCDE, 1'b0, dummy_ac, dummy_st);
        send_beat(24'h123456, 1'b1, dummy_ac, dummy_st);
        fork
            begin
                send_beat(24'h654321, 1'b0, acc_cnt, stalls);
                send_beat(24'h0FEDCB, 1'b1, dummy_ac, dummy_st);
            end
            begin
                wait_cnt(8'd0);
                capture_frame(lw, rw, ur, ae, ue);
                wait_cnt(8'd0);
                capture_frame(lw2, rw2, ur2, ae2, ue2);
            end
        join
        n_cmp++;
        if (stalls !== 255 || acc_cnt !== 8'd0) begin
            n_fail++; $display("FAIL backpressure: stalls %0d at cnt %0d required 255 at 0", stalls, acc_cnt);
        end
        n_cmp++;
        if (lw !== {1'b0, 24'h0ABCDE, 7'h0} || rw !== {1'b0, 24'h123456, 7'h0} || ur !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: got %h %h ur %b required %h %h ur 0",
                               lw, rw, ur, {1'b0, 24'h0ABCDE, 7'h0}, {1'b0, 24'h123456, 7'h0});
        end
        n_cmp++;
        if (lw2 !== {1'b0, 24'h654321, 7'h0} || rw2 !== {1'b0, 24'h0FEDCB, 7'h0} || ur2 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second: got %h %h ur %b required %h %h ur 0",
                               lw2, rw2, ur2, {1'b0, 24'h654321, 7'h0}, {1'b0, 24'h0FEDCB, 7'h0});
        end
    endtask

    task automatic test_overwrite;
        send_beat(24'h111111, 1'b0, dummy_ac, dummy_st);
        send_beat(24'h222222, 1'b0, dummy_ac, dummy_st);
        send_beat(24'h333333, 1'b1, dummy_ac, dummy_st);
        wait_cnt(8'd0);
        capture_frame(lw, rw, ur, ae, ue);
        n_cmp++;
        if (lw !== {1'b0, 24'h222222, 7'h0} || rw !== {1'b0, 24'h333333, 7'h0} || ur !== 1'b0) begin
            n_fail++; $display("FAIL overwrite: got %h %h ur %b required %h %h ur 0",
                               lw, rw, ur, {1'b0, 24'h222222, 7'h0}, {1'b0, 24'h333333, 7'h0});
        end
    endtask

    task automatic test_late_right;
        wait_cnt(8'd200);
        send_beat(24'h000002, 1'b0, dummy_ac, dummy_st);
        wait_cnt(8'd255);
        send_beat(24'h000001, 1'b1, acc_cnt, dummy_st);
        n_cmp++;
        if (acc_cnt !== 8'd255) begin
            n_fail++; $display("FAIL late_accept_cnt: got %0d required 255", acc_cnt);
        end
        capture_frame(lw, rw, ur, ae, ue);
        n_cmp++;
        if ({lw, rw} !== 64'h0 || ur !== 1'b1) begin
            n_fail++; $display("FAIL late_current_frame: got %h %h ur %b required 0 0 ur 1", lw, rw, ur);
        end
        wait_cnt(8'd0);
        capture_frame(lw, rw, ur, ae, ue);
        n_cmp++;
        if (lw !== {1'b0, 24'h000002, 7'h0} || rw !== {1'b0, 24'h000001, 7'h0} || ur !== 1'b0) begin
            n_fail++; $display("FAIL late_next_frame: got %h %h ur %b required %h %h ur 0",
                               lw, rw, ur, {1'b0, 24'h000002, 7'h0}, {1'b0, 24'h000001, 7'h0});
        end
    endtask

    task automatic test_reset_mid;
        send_beat(24'h0AAAAA, 1'b0, dummy_ac, dummy_st);
        send_beat(24'h055555, 1'b1, dummy_ac, dummy_st);
        wait_cnt(8'd100);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({s_ready, sclk, lrck, sdata, urun} !== 5'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got %b required 00000", {s_ready, sclk, lrck, sdata, urun});
        end
        @(negedge clk);
        n_cmp++;
        if ({s_ready, sclk, lrck, sdata, urun} !== 5'b0) begin
            n_fail++;
            $display("FAIL midreset_held: got %b required 00000", {s_ready, sclk, lrck, sdata, urun});
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b1 || sclk !== 1'b0) begin
            n_fail++; $display("FAIL midreset_release: ready %b sclk %b required 1 0", s_ready, sclk);
        end
        wait_cnt(8'd0);
        capture_frame(lw, rw, ur, ae, ue);
        n_cmp++;
        if ({lw, rw} !== 64'h0 || ur !== 1'b1 || ae !== 0) begin
            n_fail++; $display("FAIL midreset_first_frame: got %h %h ur %b align_err %0d required 0 0 ur 1 align_err 0",
                               lw, rw, ur, ae);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_back_to_back();
        test_overwrite();
        test_late_right();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
